// File: rtl/pipelined_addsub_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
package adder_pkg;

    localparam logic ADDSUB_ADD = 1'b0;
    localparam logic ADDSUB_SUB = 1'b1;

    typedef struct packed {
        logic overflow;
        logic zero;
        logic negative;
    } flags_t;

    function automatic int CW(input int width, input int stages);
        return width / stages;
    endfunction

    // Bit offset of the b' skew segment registered after stage s; segment s holds chunks s+1..STAGES-1.
    function automatic int bp_off(input int width, input int stages, input int s);
        return s * width - CW(width, stages) * s * (s + 1) / 2;
    endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result bus of pipelined_addsub.
// Handshake: a beat moves on a rising edge only when its valid and ready are both high; valid and
// payload hold until accepted; in_ready is combinational from out_ready.
interface pipelined_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    logic             negative;

    modport master (
        output in_valid, a, b, carry_in, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow, zero, negative
    );

    modport slave (
        input  in_valid, a, b, carry_in, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow, zero, negative
    );
endinterface

// File: rtl/pipelined_addsub_chunk.sv
// One chunk of the adder: generate/propagate ripple with carry in and out.
module adder_chunk #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a_i,
    input  logic [CW-1:0] b_i,
    input  logic          c_i,
    output logic [CW-1:0] s_o,
    output logic          c_o
);
    logic [CW-1:0] g;
    logic [CW-1:0] p;
    logic [CW:0]   c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    always_comb begin
        c    = '0;
        c[0] = c_i;
        for (int i = 0; i < CW; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign s_o = p ^ c[CW-1:0];
    assign c_o = c[CW];
endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor, one CW-bit chunk per stage, with global-stall valid/ready flow.
// Define PIPELINED_ADDSUB_FLAGS_EN to build the overflow/zero/negative flag registers.
module pipelined_addsub
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input logic                clk,
    input logic                rst,
    pipelined_addsub_if.slave  bus
);
    localparam int CHUNK_W = CW(WIDTH, STAGES);
    localparam int BP_BITS = (STAGES > 1) ? bp_off(WIDTH, STAGES, STAGES - 1) : 1;
    localparam logic [WIDTH-1:0] LOW_MASK = {WIDTH{1'b1}} >> (WIDTH - CHUNK_W);

    if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_cfg_err
        $error("pipelined_addsub: WIDTH must be a multiple of STAGES");
    end

    // word_q[s]: result chunks 0..s below, still-unused A chunks above.
    logic [WIDTH-1:0]   word_q [STAGES];
    wire  [WIDTH-1:0]   word_d [STAGES];
    logic [BP_BITS-1:0] bp_q;
    wire  [BP_BITS-1:0] bp_d;
    logic [STAGES-1:0]  carry_q;
    wire  [STAGES-1:0]  carry_d;
    logic [STAGES-1:0]  valid_q;
    logic [STAGES-1:0]  valid_d;
    logic [WIDTH-1:0]   bp_full;
    logic               adv;

    assign adv          = !(valid_q[STAGES-1] && !bus.out_ready);
    assign bus.in_ready = adv;
    assign valid_d      = (valid_q << 1) | STAGES'(bus.in_valid);
    assign bp_full      = (bus.sub == ADDSUB_SUB) ? ~bus.b : bus.b;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [CHUNK_W-1:0] op_a;
        logic [CHUNK_W-1:0] op_b;
        logic [CHUNK_W-1:0] res;
        logic               cin;
        logic               cout;

        if (s == 0) begin : g_first
            assign op_a      = bus.a[CHUNK_W-1:0];
            assign op_b      = bp_full[CHUNK_W-1:0];
            assign cin       = (bus.sub == ADDSUB_SUB) ? 1'b1 : bus.carry_in;
            assign word_d[0] = (bus.a & ~LOW_MASK) | WIDTH'(res);
        end else begin : g_next
            assign op_a      = word_q[s-1][s*CHUNK_W +: CHUNK_W];
            assign op_b      = bp_q[bp_off(WIDTH, STAGES, s - 1) +: CHUNK_W];
            assign cin       = carry_q[s-1];
            assign word_d[s] = (word_q[s-1] & ~(LOW_MASK << (s * CHUNK_W)))
                             | (WIDTH'(res) << (s * CHUNK_W));
        end

        if (s < STAGES - 1) begin : g_fwd
            localparam int FW = WIDTH - (s + 1) * CHUNK_W;
            if (s == 0) begin : g_fwd0
                assign bp_d[FW-1:0] = bp_full[WIDTH-1:CHUNK_W];
            end else begin : g_fwdn
                assign bp_d[bp_off(WIDTH, STAGES, s) +: FW] =
                    bp_q[bp_off(WIDTH, STAGES, s - 1) + CHUNK_W +: FW];
            end
        end

        adder_chunk #(.CW(CHUNK_W)) u_chunk (
            .a_i (op_a),
            .b_i (op_b),
            .c_i (cin),
            .s_o (res),
            .c_o (cout)
        );

        assign carry_d[s] = cout;
    end

    if (STAGES == 1) begin : g_no_skew
        assign bp_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            bp_q    <= '0;
            for (int s = 0; s < STAGES; s++) begin
                word_q[s] <= '0;
            end
        end else if (adv) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            bp_q    <= bp_d;
            for (int s = 0; s < STAGES; s++) begin
                word_q[s] <= word_d[s];
            end
        end
    end

    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.sum       = word_q[STAGES-1];
    assign bus.carry_out = carry_q[STAGES-1];

`ifdef PIPELINED_ADDSUB_FLAGS_EN
    flags_t flags_q;
    logic   a_msb;
    logic   bp_msb;
    logic   s_msb;

    // Operand MSBs are read from the skew registers feeding the final stage.
    if (STAGES == 1) begin : g_msb_one
        assign a_msb  = bus.a[WIDTH-1];
        assign bp_msb = bp_full[WIDTH-1];
    end else begin : g_msb_skew
        assign a_msb  = word_q[STAGES-2][WIDTH-1];
        assign bp_msb = bp_q[bp_off(WIDTH, STAGES, STAGES - 2) + CHUNK_W - 1];
    end
    assign s_msb = word_d[STAGES-1][WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
        end else if (adv) begin
            flags_q <= '{overflow: (a_msb == bp_msb) && (s_msb != a_msb),
                         zero:     (word_d[STAGES-1] == '0),
                         negative: s_msb};
        end
    end

    assign bus.overflow = flags_q.overflow;
    assign bus.zero     = flags_q.zero;
    assign bus.negative = flags_q.negative;
`else
    assign bus.overflow = 1'b0;
    assign bus.zero     = 1'b0;
    assign bus.negative = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub: vector table, back-pressure stream, reset corner cases.
module tb_pipelined_addsub;
    localparam int W  = 32;
    localparam int S  = 4;
    localparam int EW = W + 4;
`ifdef PIPELINED_ADDSUB_FLAGS_EN
    localparam logic FLAGS = 1'b1;
`else
    localparam logic FLAGS = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ov;
        logic         z;
        logic         n;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    int   stall_waits = 0;
    logic stream_done;
    logic stall_prev = 1'b0;
    logic [EW:0]   held;
    logic [EW-1:0] exp_q[$];
    vec_t vecs[12];

    always #5 clk = ~clk;

    pipelined_addsub_if #(.WIDTH(W)) bus ();

    pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] exp_of(input vec_t v);
        return {v.sum, v.cout, v.ov & FLAGS, v.z & FLAGS, v.n & FLAGS};
    endfunction

    // Scoreboard: every retired beat is popped and compared; stalled outputs must hold.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check("stall_hold", {bus.sum, bus.carry_out, bus.overflow, bus.zero,
                                     bus.negative, bus.out_valid}, held);
            if (bus.out_valid && bus.out_ready) begin
                check("sb_has_entry", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sum",       bus.sum,       e[EW-1:4]);
                    check("carry_out", bus.carry_out, e[3]);
                    check("overflow",  bus.overflow,  e[2]);
                    check("zero",      bus.zero,      e[1]);
                    check("negative",  bus.negative,  e[0]);
                end
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            held = {bus.sum, bus.carry_out, bus.overflow, bus.zero, bus.negative, bus.out_valid};
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int idx);
        int waits;
        waits        = 0;
        bus.in_valid = 1'b1;
        bus.a        = vecs[idx].a;
        bus.b        = vecs[idx].b;
        bus.carry_in = vecs[idx].cin;
        bus.sub      = vecs[idx].sub;
        @(negedge clk);
        while (!bus.in_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 200)
            check("accept_timeout", bus.in_ready, 1);
        else
            exp_q.push_back(exp_of(vecs[idx]));
        stall_waits += waits;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic check_latency(input string tag);
        repeat (S - 2) @(posedge clk);
        @(negedge clk);
        check({tag, "_early"}, bus.out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_latency"}, bus.out_valid, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{32'h00FFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h01000000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1};

        // Reset with a live beat on the input: nothing may enter.
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a         = 32'hFFFFFFFF;
        bus.b         = 32'h00000001;
        bus.carry_in  = 1'b1;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_sum",       bus.sum,       0);
        check("rst_carry_out", bus.carry_out, 0);
        check("rst_overflow",  bus.overflow,  0);
        check("rst_zero",      bus.zero,      0);
        check("rst_negative",  bus.negative,  0);
        check("rst_in_ready",  bus.in_ready,  1);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;

        // Single beats with exact latency.
        for (int i = 0; i < 12; i++) begin
            send(i);
            check_latency($sformatf("vec%0d", i));
        end

        // Full throughput: no refused beats with out_ready held high.
        stall_waits = 0;
        for (int i = 0; i < 8; i++) send(i);
        check("throughput_waits", stall_waits, 0);
        repeat (S + 1) @(posedge clk);
        #1;
        check("throughput_drain", exp_q.size(), 0);

        // Back-pressure stream with random out_ready.
        stream_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) send(i % 12);
                for (int c = 0; c < 500 && exp_q.size() != 0; c++) @(posedge clk);
                check("stream_drain", exp_q.size(), 0);
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
                bus.out_ready = 1'b1;
            end
        join
        @(posedge clk);
        #1;

        // Reset with three beats in flight.
        send(3);
        send(4);
        send(5);
        rst = 1'b1;
        #1;
        check("midrst_async_valid", bus.out_valid, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < S; i++) begin
            @(negedge clk);
            check("midrst_no_stale", bus.out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(2);
        check_latency("post_rst");

        repeat (2) @(posedge clk);
        check("final_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined adder/subtractor that generalises the team's flat 32-bit carry-lookahead adder to any width. The operand is split into STAGES equal chunks, one chunk per pipeline stage, with the carry registered between stages. A valid/ready handshake supports back-pressure, and an ADD/SUB mode is selectable per operation. The block sits in the execute path wherever a wide add needs to close timing at full clock rate, e.g. address generation and the multiply/accumulate datapath.

## Interface
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth and chunk count; 1..WIDTH; chunk width CW = WIDTH/STAGES.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- carry_in  in  1  carry into bit 0 in ADD mode; ignored in SUB mode.
- sub  in  1  0 = A+B+carry_in; 1 = A-B (A + ~B + 1).
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- carry_out  out  1  carry out of the MSB; in SUB mode 1 means no borrow.
- overflow  out  1  signed overflow.
- zero  out  1  sum == 0.
- negative  out  1  sum[WIDTH-1].

## Operation
- Beat accepted when in_valid && in_ready. Pipeline advances when adv = !(out_valid && !out_ready). in_ready = adv.
- Stall is global: all stages hold while !adv. Bubbles are carried as invalid stages; they are not collapsed.
- Stage s (0..STAGES-1):
  - Computes chunk s = a_s + b'_s + c_s, where b' = sub ? ~b : b.
  - c_0 = sub ? 1 : carry_in; c_s (s>0) is the registered carry from stage s-1.
- Operand bits of higher chunks travel in skew registers. Lower result chunks travel in de-skew registers, so the whole sum emerges aligned.
- Each stage carries a valid bit. out_valid is the final stage's valid bit.
- overflow = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]). It is computed in the final stage from the skewed MSBs.
- zero and negative are computed in the final stage from the aligned sum.
- Results leave in acceptance order; no reordering, no drop, no duplication.
- Arithmetic is modulo 2^WIDTH; no saturation.

## Timing
- Latency: a beat accepted at edge k is on the outputs (out_valid=1) after edge k+STAGES-1, provided there is no stall.
- Throughput is 1 beat/cycle with out_ready held high.
- Outputs are registered; no combinational path from a/b to sum.
- in_ready depends combinationally on out_ready (single AND-level). This is documented for integrators.
- Outputs stay stable while out_valid && !out_ready.
- Reset value of every output: out_valid=0, sum=0, carry_out=0, overflow=0, zero=0, negative=0.
  - in_ready=1 in reset, because out_valid=0.
- Reset mid-operation: all in-flight beats are discarded and every valid bit clears immediately (asynchronous). The first beat after reset deassertion behaves as from power-up.
- Simultaneous accept and retire in the same cycle is legal and required for full throughput.
- STAGES=1 degenerates to a single registered adder with latency 1.

## Configuration
- PIPELINED_ADDSUB_FLAGS_EN defined:
  - overflow, zero and negative are computed and registered as above.
- Undefined:
  - The flag logic and registers are removed.
  - overflow, zero and negative are tied to 0.
  - sum, carry_out and handshake behaviour are identical in both builds.

## Structure
- Package adder_pkg holds:
  - the ADDSUB_ADD/ADDSUB_SUB mode constants;
  - the chunk-width function CW(WIDTH, STAGES);
  - a packed flags struct {overflow, zero, negative}.
- Sub-module adder_chunk: one CW-bit generate/propagate ripple (G = a&b, P = a^b) with carry in/out.
  - Instantiated STAGES times in a generate loop.
  - Skew/de-skew registers and valid bits live in the top level.
- Elaboration-time check: WIDTH % STAGES == 0, else $error.

## Test plan
- Reset: assert rst for 3 cycles with in_valid=1 -> out_valid=0, sum=0, all flags 0, in_ready=1.
- ADD wrap: a=0xFFFFFFFF, b=0x00000000, carry_in=1 -> after 4 edges sum=0x00000000, carry_out=1, zero=1, overflow=0.
- SUB borrow: sub=1, a=5, b=7 -> sum=0xFFFFFFFE, carry_out=0, negative=1, overflow=0.
- Signed overflow: a=0x7FFFFFFF, b=1, carry_in=0 -> sum=0x80000000, overflow=1, negative=1.
  - With PIPELINED_ADDSUB_FLAGS_EN undefined: overflow=0 and sum unchanged.
- Back-pressure stream: 16 random beats back-to-back, out_ready toggled pseudo-randomly -> all 16 results correct, in order, no loss; outputs stable during stalls.
- Reset mid-flight: rst pulsed with 3 beats in flight -> no stale out_valid after reset; the next beat returns the correct result after 4 edges.
